// File: rtl/ram_stream_fifo_ctrl.sv
// Valid/ready stream FIFO controller around an external simple dual-port RAM.
// The RAM's registered read output acts as the single output data stage.
module ram_stream_fifo_ctrl #(
    parameter int WIDTH_DATA = 16,
    parameter int NUMWORDS   = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [WIDTH_DATA-1:0]           s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [WIDTH_DATA-1:0]           m_data,
    output logic [$clog2(NUMWORDS+2)-1:0]   level,
    output logic                            ram_wr_en,
    output logic [$clog2(NUMWORDS)-1:0]     ram_wr_addr,
    output logic [WIDTH_DATA-1:0]           ram_wr_data,
    output logic                            ram_rd_en,
    output logic [$clog2(NUMWORDS)-1:0]     ram_rd_addr,
    input  logic [WIDTH_DATA-1:0]           ram_rd_data
);

    localparam int AW = $clog2(NUMWORDS);
    localparam int CW = $clog2(NUMWORDS + 1);
    localparam int LW = $clog2(NUMWORDS + 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUMWORDS);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          rst_done;

    // Handshakes depend on registered state only; a same-cycle read never frees a slot.
    assign s_ready     = rst_done & ~flush & (ram_cnt != FULL_CNT);
    assign ram_wr_en   = s_valid & s_ready;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = s_data;

    assign ram_rd_en   = rst_done & ~flush & (ram_cnt != '0) & (~m_valid | m_ready);
    assign ram_rd_addr = rd_ptr;

    assign m_data      = ram_rd_data;
    assign level       = LW'(ram_cnt) + LW'(m_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            m_valid  <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                ram_cnt <= '0;
                m_valid <= 1'b0;
            end else begin
                if (ram_wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (ram_rd_en) rd_ptr <= rd_ptr + AW'(1);
                ram_cnt <= ram_cnt + CW'(ram_wr_en) - CW'(ram_rd_en);
                if (ram_rd_en)
                    m_valid <= 1'b1;
                else if (m_ready)
                    m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Self-checking bench: behavioural word-queue model plus a registered-read RAM model.
module tb_ram_stream_fifo_ctrl;

    localparam int W = 16;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [3:0]    level;
    logic          ram_wr_en;
    logic [2:0]    ram_wr_addr;
    logic [W-1:0]  ram_wr_data;
    logic          ram_rd_en;
    logic [2:0]    ram_rd_addr;
    logic [W-1:0]  ram_rd_data;

    int checks = 0;
    int failures = 0;

    ram_stream_fifo_ctrl #(.WIDTH_DATA(W), .NUMWORDS(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM with registered read
    logic [W-1:0] mem [0:N-1];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    // Reference: q holds every word inside the FIFO, front = word in output stage
    logic [W-1:0] q[$];
    int  ram_n;
    bit  out_full;
    bit  m_done;
    int  pop_cnt = 0;
    bit  mw, mr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); ram_n = 0; out_full = 0; m_done = 0;
        end else if (!m_done) begin
            m_done = 1;
        end else if (flush) begin
            q.delete(); ram_n = 0; out_full = 0;
        end else begin
            mw = s_valid && (ram_n < N);
            mr = (ram_n > 0) && (!out_full || m_ready);
            if (out_full && m_ready) begin
                void'(q.pop_front());
                pop_cnt++;
            end
            if (mw) q.push_back(s_data);
            ram_n = ram_n + int'(mw) - int'(mr);
            out_full = mr || (out_full && !m_ready);
        end
    end

    wire       e_s_ready = m_done && !flush && (ram_n < N);
    wire       e_rd_en   = m_done && !flush && (ram_n > 0) && (!out_full || m_ready);
    wire [3:0] e_level   = 4'(ram_n + int'(out_full));

    task automatic drive(input logic sv, input logic [W-1:0] d, input logic mrdy, input logic fl);
        @(negedge clk);
        s_valid = sv; s_data = d; m_ready = mrdy; flush = fl;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; s_valid = 0; m_ready = 0; s_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({s_ready, m_valid, level, ram_wr_en, ram_rd_en} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state s_ready=%b m_valid=%b level=%0d wr_en=%b rd_en=%b (all 0 required)",
                     s_ready, m_valid, level, ram_wr_en, ram_rd_en);
        end
        @(negedge clk); rst_n = 1'b1; s_valid = 1'b1; #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++; $display("FAIL reset_first_cycle s_ready=%b required 0", s_ready);
        end
        drive(0, '0, 0, 0);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_after s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_single();
        drive(1, 16'hA5A5, 1, 0);
        drive(0, '0, 1, 0);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++; $display("FAIL single_latency m_valid=%b required 0", m_valid);
        end
        drive(0, '0, 1, 0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'hA5A5 || level !== 4'd1) begin
            failures++;
            $display("FAIL single_word m_valid=%b m_data=%h level=%0d required 1 a5a5 1", m_valid, m_data, level);
        end
        drive(0, '0, 1, 0);
        checks++;
        if (m_valid !== 1'b0 || level !== 4'd0) begin
            failures++; $display("FAIL single_drain m_valid=%b level=%0d required 0 0", m_valid, level);
        end
    endtask

    task automatic test_streaming();
        int idx = 1;
        int p0 = pop_cnt;
        for (int c = 0; c < 45; c++) begin
            drive(idx <= 32, 16'(idx), 1, 0);
            checks++;
            if (s_ready !== e_s_ready || m_valid !== out_full || level !== e_level || level > 4'd2) begin
                failures++;
                $display("FAIL stream_state c=%0d s_ready=%b/%b m_valid=%b/%b level=%0d/%0d",
                         c, s_ready, e_s_ready, m_valid, out_full, level, e_level);
            end
            if (out_full) begin
                checks++;
                if (m_data !== q[0]) begin
                    failures++; $display("FAIL stream_data c=%0d m_data=%h required %h", c, m_data, q[0]);
                end
            end
            if (idx <= 32 && s_ready) idx++;
        end
        checks++;
        if (pop_cnt - p0 != 32) begin
            failures++; $display("FAIL stream_count popped=%0d required 32", pop_cnt - p0);
        end
    endtask

    task automatic test_fill();
        int acc = 0;
        int p0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 16'(acc + 1), 0, 0);
            checks++;
            if (s_ready !== e_s_ready || ram_wr_en !== (e_s_ready && 1'b1) || level !== e_level) begin
                failures++;
                $display("FAIL fill_state c=%0d s_ready=%b/%b level=%0d/%0d", c, s_ready, e_s_ready, level, e_level);
            end
            if (s_ready) acc++;
        end
        drive(0, '0, 0, 0);
        checks++;
        if (acc != 9 || level !== 4'd9 || s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 16'd1) begin
            failures++;
            $display("FAIL fill_full acc=%0d level=%0d s_ready=%b m_valid=%b m_data=%h required 9 9 0 1 0001",
                     acc, level, s_ready, m_valid, m_data);
        end
        p0 = pop_cnt;
        for (int c = 0; c < 12; c++) begin
            drive(0, '0, 1, 0);
            checks++;
            if (s_ready !== e_s_ready || m_valid !== out_full || level !== e_level) begin
                failures++;
                $display("FAIL drain_state c=%0d s_ready=%b/%b m_valid=%b/%b level=%0d/%0d",
                         c, s_ready, e_s_ready, m_valid, out_full, level, e_level);
            end
            if (out_full) begin
                checks++;
                if (m_data !== q[0]) begin
                    failures++; $display("FAIL drain_data c=%0d m_data=%h required %h", c, m_data, q[0]);
                end
            end
        end
        checks++;
        if (pop_cnt - p0 != 9) begin
            failures++; $display("FAIL drain_count popped=%0d required 9", pop_cnt - p0);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) drive(1, 16'(16'h100 + i), 0, 0);
        for (int c = 0; c < 10; c++) begin
            drive(1, 16'(16'h200 + c), 1, 0);
            checks++;
            if (level !== 4'd4 || level !== e_level) begin
                failures++; $display("FAIL simul_level c=%0d level=%0d required 4", c, level);
            end
            checks++;
            if (m_valid !== 1'b1 || m_data !== q[0]) begin
                failures++; $display("FAIL simul_data c=%0d m_valid=%b m_data=%h required 1 %h", c, m_valid, m_data, q[0]);
            end
            checks++;
            if (ram_wr_en && ram_rd_en && ram_wr_addr == ram_rd_addr) begin
                failures++; $display("FAIL simul_hazard c=%0d wr_addr=%0d rd_addr=%0d required distinct", c, ram_wr_addr, ram_rd_addr);
            end
        end
    endtask

    task automatic test_flush();
        drive(0, '0, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 16'(16'h300 + i), 0, 0);
        drive(1, 16'h0BAD, 1, 1);
        checks++;
        if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0 || s_ready !== 1'b0) begin
            failures++; $display("FAIL flush_cycle wr_en=%b rd_en=%b s_ready=%b required 0 0 0", ram_wr_en, ram_rd_en, s_ready);
        end
        drive(1, 16'h1234, 1, 0);
        checks++;
        if (m_valid !== 1'b0 || level !== 4'd0) begin
            failures++; $display("FAIL flush_after m_valid=%b level=%0d required 0 0", m_valid, level);
        end
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h1234 || level !== 4'd1) begin
            failures++; $display("FAIL flush_push m_valid=%b m_data=%h level=%0d required 1 1234 1", m_valid, m_data, level);
        end
        drive(0, '0, 1, 0);
        checks++;
        if (m_valid !== 1'b0 || level !== 4'd0) begin
            failures++; $display("FAIL flush_only m_valid=%b level=%0d required 0 0", m_valid, level);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) drive(1, 16'(16'h400 + i), 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || level !== 4'd0 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset m_valid=%b s_ready=%b level=%0d wr_en=%b required 0 0 0 0",
                     m_valid, s_ready, level, ram_wr_en);
        end
        @(negedge clk); rst_n = 1'b1;
        drive(0, '0, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            checks++;
            if (s_ready !== e_s_ready || m_valid !== out_full || level !== e_level ||
                ram_rd_en !== e_rd_en || ram_wr_en !== (s_valid && e_s_ready)) begin
                failures++;
                $display("FAIL random_state c=%0d s_ready=%b/%b m_valid=%b/%b level=%0d/%0d rd_en=%b/%b",
                         c, s_ready, e_s_ready, m_valid, out_full, level, e_level, ram_rd_en, e_rd_en);
            end
            if (out_full) begin
                checks++;
                if (m_data !== q[0]) begin
                    failures++; $display("FAIL random_data c=%0d m_data=%h required %h", c, m_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_fill();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
